// File: rtl/conv2d_pkg.sv
// Shared types and helpers for conv2d_seq: FSM state encoding, derived
// datapath widths and a generic signed saturation function.
package conv2d_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [63:0] value;
    logic               flag;
  } sat_t;

  function automatic int prod_width(input int pix_w, input int coef_w);
    return pix_w + coef_w;
  endfunction

  function automatic int acc_width(input int prod_w, input int n);
    return prod_w + $clog2(n);
  endfunction

  // Clip a wide signed value into the range of an out_w-bit signed number.
  function automatic sat_t saturate(input logic signed [63:0] value, input int out_w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sat_t               r;
    max_v   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (out_w - 1));
    r.value = value;
    r.flag  = 1'b0;
    if (value > max_v) begin
      r.value = max_v;
      r.flag  = 1'b1;
    end else if (value < min_v) begin
      r.value = min_v;
      r.flag  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv2d_lane_sum.sv
// Combinational sum of LANES signed pixel*coefficient products; a lane
// whose enable is low contributes zero.
module conv2d_lane_sum
  import conv2d_pkg::*;
#(
  parameter int LANES  = 3,
  parameter int PIX_W  = 9,
  parameter int COEF_W = 8,
  parameter int SUM_W  = 21
) (
  input  logic [LANES-1:0][PIX_W-1:0]  pix,
  input  logic [LANES-1:0][COEF_W-1:0] coef,
  input  logic [LANES-1:0]             en,
  output logic signed [SUM_W-1:0]      sum
);

  localparam int PROD_W = prod_width(PIX_W, COEF_W);

  logic signed [PROD_W-1:0] prod [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_mul
    logic signed [PROD_W-1:0] pix_x;
    logic signed [PROD_W-1:0] coef_x;
    // Operands are widened to the full product width first so the multiply is exact.
    assign pix_x    = en[gi] ? PROD_W'($signed(pix[gi]))  : '0;
    assign coef_x   = en[gi] ? PROD_W'($signed(coef[gi])) : '0;
    assign prod[gi] = pix_x * coef_x;
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + SUM_W'(prod[i]);
    end
  end

endmodule

// File: rtl/conv2d_seq.sv
// Multi-cycle KxK convolution: LANES products per beat, then x2^SHIFT, bias, saturate.
// Optional CONV2D_SEQ_RELU_EN forces negative results to zero after saturation.
module conv2d_seq
  import conv2d_pkg::*;
#(
  parameter int K_SIZE = 3,
  parameter int PIX_W  = 9,
  parameter int COEF_W = 8,
  parameter int BIAS_W = 8,
  parameter int LANES  = 3,
  parameter int SHIFT  = 1,
  parameter int OUT_W  = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [K_SIZE-1:0][K_SIZE-1:0][PIX_W-1:0]  window,
  input  logic [K_SIZE-1:0][K_SIZE-1:0][COEF_W-1:0] kernel,
  input  logic signed [BIAS_W-1:0]                  bias,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic signed [OUT_W-1:0]                   result,
  output logic                                      out_sat
);

  localparam int N      = K_SIZE * K_SIZE;
  localparam int PROD_W = prod_width(PIX_W, COEF_W);
  localparam int ACC_W  = acc_width(PROD_W, N);
  localparam int FULL_W = ((ACC_W + SHIFT > BIAS_W) ? ACC_W + SHIFT : BIAS_W) + 1;
  localparam int IDX_W  = $clog2(N + LANES);
  localparam int TAPS_P = 1 << IDX_W;

  state_t                                    state_reg, state_next;
  logic [K_SIZE-1:0][K_SIZE-1:0][PIX_W-1:0]  win_reg;
  logic [K_SIZE-1:0][K_SIZE-1:0][COEF_W-1:0] ker_reg;
  logic signed [BIAS_W-1:0]                  bias_reg;
  logic signed [ACC_W-1:0]                   acc_reg, beat_sum, acc_sum;
  logic [IDX_W-1:0]                          idx_reg;
  logic [IDX_W:0]                            idx_end;
  logic                                      in_ready_reg, in_ready_next;
  logic                                      accept, last_beat;
  logic signed [OUT_W-1:0]                   result_reg;
  logic                                      out_sat_reg;
  logic signed [FULL_W-1:0]                  s_full;
  sat_t                                      sat_v;
  logic [63-OUT_W:0]                         sat_high_unused;
  logic signed [OUT_W-1:0]                   sat_value, res_value;
  logic                                      res_flag;

  // Taps are zero-padded past N so lanes running off the end index safely.
  logic [TAPS_P-1:0][PIX_W-1:0]              win_pad;
  logic [TAPS_P-1:0][COEF_W-1:0]             ker_pad;
  logic [LANES-1:0][PIX_W-1:0]               lane_pix;
  logic [LANES-1:0][COEF_W-1:0]              lane_coef;
  logic [LANES-1:0]                          lane_en;

  assign win_pad = {{((TAPS_P - N) * PIX_W){1'b0}}, win_reg};
  assign ker_pad = {{((TAPS_P - N) * COEF_W){1'b0}}, ker_reg};

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [IDX_W-1:0] tap;
    assign tap           = idx_reg + IDX_W'(gi);
    assign lane_en[gi]   = (tap < IDX_W'(N));
    assign lane_pix[gi]  = win_pad[tap];
    assign lane_coef[gi] = ker_pad[tap];
  end

  conv2d_lane_sum #(
    .LANES  (LANES),
    .PIX_W  (PIX_W),
    .COEF_W (COEF_W),
    .SUM_W  (ACC_W)
  ) u_lane_sum (
    .pix  (lane_pix),
    .coef (lane_coef),
    .en   (lane_en),
    .sum  (beat_sum)
  );

  assign idx_end   = {1'b0, idx_reg} + (IDX_W+1)'(LANES);
  assign last_beat = (idx_end >= (IDX_W+1)'(N));
  assign acc_sum   = acc_reg + beat_sum;
  assign s_full    = (FULL_W'(acc_sum) <<< SHIFT) + FULL_W'(bias_reg);
  assign sat_v     = saturate(64'(s_full), OUT_W);
  assign {sat_high_unused, sat_value} = sat_v.value;

`ifdef CONV2D_SEQ_RELU_EN
  assign res_value = sat_value[OUT_W-1] ? '0 : sat_value;
  assign res_flag  = sat_value[OUT_W-1] ? 1'b0 : sat_v.flag;
`else
  assign res_value = sat_value;
  assign res_flag  = sat_v.flag;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept)    state_next = ACCUM;
      ACCUM:   if (last_beat) state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // in_ready_reg is only ever high in IDLE, so it alone qualifies an input transfer.
  always_comb begin
    accept        = in_valid && in_ready_reg;
    out_valid     = (state_reg == OUT);
    in_ready_next = (state_next == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_reg <= 1'b0;
      win_reg      <= '0;
      ker_reg      <= '0;
      bias_reg     <= '0;
      acc_reg      <= '0;
      idx_reg      <= '0;
      result_reg   <= '0;
      out_sat_reg  <= 1'b0;
    end else begin
      in_ready_reg <= in_ready_next;
      if (accept) begin
        win_reg  <= window;
        ker_reg  <= kernel;
        bias_reg <= bias;
        acc_reg  <= '0;
        idx_reg  <= '0;
      end else if (state_reg == ACCUM) begin
        acc_reg <= acc_sum;
        idx_reg <= idx_reg + IDX_W'(LANES);
        if (last_beat) begin
          result_reg  <= res_value;
          out_sat_reg <= res_flag;
        end
      end
    end
  end

  assign in_ready = in_ready_reg;
  assign result   = result_reg;
  assign out_sat  = out_sat_reg;

endmodule

// File: tb/tb_conv2d_seq.sv
// Scoreboard bench for conv2d_seq (default build and CONV2D_SEQ_RELU_EN build),
// plus a LANES=4 instance for the zero-padded-lane case.
`timescale 1ns/1ps
module tb_conv2d_seq;

  localparam int K      = 3;
  localparam int PIX_W  = 9;
  localparam int COEF_W = 8;
  localparam int BIAS_W = 8;
  localparam int SHIFT  = 1;
  localparam int OUT_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                                 in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [K-1:0][K-1:0][PIX_W-1:0]       window;
  logic [K-1:0][K-1:0][COEF_W-1:0]      kernel;
  logic signed [BIAS_W-1:0]             bias;
  logic signed [OUT_W-1:0]              result;
  logic                                 in_valid4, in_ready4, out_valid4, out_ready4, out_sat4;
  logic signed [OUT_W-1:0]              result4;

  conv2d_seq #(.K_SIZE(K), .PIX_W(PIX_W), .COEF_W(COEF_W), .BIAS_W(BIAS_W),
               .LANES(3), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .window(window), .kernel(kernel), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_sat(out_sat)
  );

  conv2d_seq #(.K_SIZE(K), .PIX_W(PIX_W), .COEF_W(COEF_W), .BIAS_W(BIAS_W),
               .LANES(4), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .window(window), .kernel(kernel), .bias(bias),
    .out_valid(out_valid4), .out_ready(out_ready4), .result(result4), .out_sat(out_sat4)
  );

  typedef struct { int res; int sat; } exp_t;
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   w[9];
  int   k[9];
  int   b;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model();
    longint s = 0;
    longint max_v = (64'sd1 <<< (OUT_W - 1)) - 1;
    longint min_v = -(64'sd1 <<< (OUT_W - 1));
    exp_t   e;
    for (int i = 0; i < 9; i++) s += longint'(w[i]) * longint'(k[i]);
    s = s * (longint'(1) <<< SHIFT) + longint'(b);
    if (s > max_v)      begin e.res = int'(max_v); e.sat = 1; end
    else if (s < min_v) begin e.res = int'(min_v); e.sat = 1; end
    else                begin e.res = int'(s);     e.sat = 0; end
`ifdef CONV2D_SEQ_RELU_EN
    if (e.res < 0) begin e.res = 0; e.sat = 0; end
`endif
    return e;
  endfunction

  task automatic fill(input int wv, input int kv, input int bv);
    for (int i = 0; i < 9; i++) begin w[i] = wv; k[i] = kv; end
    b = bv;
  endtask

  task automatic load_ops();
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        window[r][c] = w[r*K+c][PIX_W-1:0];
        kernel[r][c] = k[r*K+c][COEF_W-1:0];
      end
    bias = b[BIAS_W-1:0];
  endtask

  // Called just after a rising edge; returns 1 ns after the accepting edge.
  task automatic wait_accept();
    logic rdy;
    bit   ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) ok = 1;
    end
    #1;
    in_valid = 1'b0;
    if (ok) sb.push_back(model());
    else    check("accept_timeout", 0, 1);
  endtask

  task automatic send();
    load_ops();
    in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic wait_out(output int edges);
    edges = 0;
    while (!out_valid && edges < 50) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("out_sat", out_sat, e.sat);
        $display("out: result=%0d sat=%0d (expected %0d/%0d)", result, out_sat, e.res, e.sat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   edges;
    exp_t ea;
    in_valid = 0; in_valid4 = 0; out_ready = 1; out_ready4 = 1;
    fill(0, 0, 0);
    load_ops();
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_out_sat", out_sat, 0);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", in_ready, 1);

    // all ones: 18, latency of 3 beats
    fill(1, 1, 0); send(); wait_out(edges);
    check("latency", edges, 3);
    @(posedge clk); #1;
    fill(255, 127, 127); send(); wait_out(edges);
    @(posedge clk); #1;
    fill(-1, 5, -3); send(); wait_out(edges);
    @(posedge clk); #1;
    fill(-256, 127, 0); send(); wait_out(edges);
    @(posedge clk); #1;
    fill(-256, -128, -128); send(); wait_out(edges);
    @(posedge clk); #1;

    // backpressure with a second window waiting
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin w[i] = i - 4; k[i] = 2*i - 7; end
    b = 10;
    ea = model();
    send(); wait_out(edges);
    check("bp_latency", edges, 3);
    for (int i = 0; i < 9; i++) begin w[i] = 30 * i - 100; k[i] = 11 - 3*i; end
    b = -20;
    load_ops();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_result", result, ea.res);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept(); wait_out(edges);
    @(posedge clk); #1;

    // reset in the second accumulate beat
    fill(2, 3, 1); send();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_result", result, 0);
    check("abort_out_sat", out_sat, 0);
    void'(sb.pop_back());
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_hold_valid", out_valid, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_abort", in_ready, 1);
    fill(3, -2, -7); send(); wait_out(edges);
    check("post_abort_latency", edges, 3);
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 9; i++) begin
        w[i] = int'($urandom_range(511)) - 256;
        k[i] = int'($urandom_range(255)) - 128;
      end
      b = int'($urandom_range(255)) - 128;
      send(); wait_out(edges);
      @(posedge clk); #1;
    end

    // LANES=4 instance: last beat has three padded lanes
    fill(1, 1, 0); load_ops();
    in_valid4 = 1'b1;
    begin
      logic rdy;
      bit   ok = 0;
      for (int n = 0; n < 20 && !ok; n++) begin
        @(negedge clk); rdy = in_ready4;
        @(posedge clk); if (rdy) ok = 1;
      end
      #1;
      in_valid4 = 1'b0;
      check("l4_accept", ok, 1);
    end
    edges = 0;
    while (!out_valid4 && edges < 50) begin
      @(posedge clk); #1; edges++;
    end
    check("l4_latency", edges, 3);
    check("l4_result", result4, 18);
    check("l4_out_sat", out_sat4, 0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
